// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the instruction-memory loader.
//
// Contents:
//   load_state_e      : loader FSM state encoding (IDLE, RECV, WRITE, FINISH)
//   DEPTH             : instruction-memory depth in 32-bit words
//   WORD_ADDR_SHIFT   : shift turning a word index into a byte address
//   word_to_byte_addr : helper applying that shift, zero-extended to 64 bits
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } load_state_e;

  localparam int DEPTH           = 32;
  localparam int WORD_ADDR_SHIFT = 2;

  // Instruction words are 4 bytes wide, so the byte address is index << 2.
  function automatic logic [63:0] word_to_byte_addr(input logic [5:0] wordIdx);
    return 64'(wordIdx) << WORD_ADDR_SHIFT;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader -- streams bytes from a byte source into the instruction memory
// while holding the CPU core stalled.
//
// A session is opened by start in IDLE. Bytes are gathered little-endian into
// 32-bit words; each finished word is written with a one-cycle load_en strobe
// at byte address word_index*4. After num_words words a one-cycle done pulse
// is issued. A bad length (0 or more than DEPTH) sets the sticky err flag and
// finishes at once without receiving anything.
//
// Ports:
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   start, num_words : session request and its word count (sampled in IDLE)
//   byte_valid/data  : byte source offer
//   byte_ready       : loader accepts a byte this cycle (RECV only)
//   load_en/data/addr: instruction-memory write port
//   cpu_hold         : stalls the core while a session is active
//   done, err        : success pulse, sticky bad-length flag
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = cpu_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              load_en,
  output logic [31:0]       load_data,
  output logic [ADDR_W-1:0] load_addr,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [5:0] DepthLimit = 6'(DEPTH);

  load_state_e       state_q;
  logic [5:0]        numWords_q;
  logic [5:0]        wordIdx_q;
  logic [1:0]        byteCnt_q;
  logic [23:0]       shift_q;
  logic              byteReady_q;
  logic              loadEn_q;
  logic [31:0]       loadData_q;
  logic [ADDR_W-1:0] loadAddr_q;
  logic              cpuHold_q;
  logic              done_q;
  logic              err_q;

  logic [31:0]       assembledWord_d;
  logic [ADDR_W-1:0] wordAddr_d;
  logic              lengthOk_d;
  logic              lastWord_d;

  // Earlier bytes sit in the shift register; the byte being accepted now
  // completes the word in the top lane, giving little-endian order.
  always_comb begin
    assembledWord_d = {byte_data, shift_q};
    wordAddr_d      = ADDR_W'(word_to_byte_addr(wordIdx_q));
    lengthOk_d      = (num_words != 6'd0) && (num_words <= DepthLimit);
    lastWord_d      = ((wordIdx_q + 6'd1) == numWords_q);
  end

  // Loader FSM. All outputs are registered and updated on the transition
  // into the state they belong to, so they are clean for the whole cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      numWords_q  <= '0;
      wordIdx_q   <= '0;
      byteCnt_q   <= '0;
      shift_q     <= '0;
      byteReady_q <= 1'b0;
      loadEn_q    <= 1'b0;
      loadData_q  <= '0;
      loadAddr_q  <= '0;
      cpuHold_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      loadEn_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            numWords_q <= num_words;
            wordIdx_q  <= '0;
            byteCnt_q  <= '0;
            if (lengthOk_d) begin
              err_q       <= 1'b0;
              state_q     <= ST_RECV;
              byteReady_q <= 1'b1;
              cpuHold_q   <= 1'b1;
            end else begin
              // Bad length: skip reception entirely, finish without done.
              err_q   <= 1'b1;
              state_q <= ST_FINISH;
            end
          end
        end

        ST_RECV: begin
          if (byte_valid && byteReady_q) begin
            shift_q   <= assembledWord_d[31:8];
            byteCnt_q <= byteCnt_q + 2'd1;
            if (byteCnt_q == 2'd3) begin
              state_q     <= ST_WRITE;
              byteReady_q <= 1'b0;
              loadEn_q    <= 1'b1;
              loadData_q  <= assembledWord_d;
              loadAddr_q  <= wordAddr_d;
            end
          end
        end

        ST_WRITE: begin
          wordIdx_q <= wordIdx_q + 6'd1;
          byteCnt_q <= '0;
          if (lastWord_d) begin
            state_q   <= ST_FINISH;
            cpuHold_q <= 1'b0;
            done_q    <= ~err_q;
          end else begin
            state_q     <= ST_RECV;
            byteReady_q <= 1'b1;
          end
        end

        ST_FINISH: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign byte_ready = byteReady_q;
  assign load_en    = loadEn_q;
  assign load_data  = loadData_q;
  assign load_addr  = loadAddr_q;
  assign cpu_hold   = cpuHold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- directed self-checking bench for imem_loader.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_imem_loader;

  localparam int ADDR_W = 64;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [5:0]        num_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              load_en;
  logic [31:0]       load_data;
  logic [ADDR_W-1:0] load_addr;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int checks;
  int failures;

  logic [ADDR_W-1:0] wrAddr[$];
  logic [31:0]       wrData[$];
  int                readyCount;
  int                holdCount;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .num_words(num_words),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .load_en(load_en),
    .load_data(load_data),
    .load_addr(load_addr),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Records every write strobe and counts ready/hold cycles.
  always @(negedge clk) begin
    if (load_en) begin
      wrAddr.push_back(load_addr);
      wrData.push_back(load_data);
    end
    if (byte_ready) readyCount++;
    if (cpu_hold) holdCount++;
  end

  // Hard stop in case a session never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Opens a session; called and returns on a falling edge.
  task automatic startSession(input logic [5:0] n);
    start     = 1'b1;
    num_words = n;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Offers one byte until accepted; returns on the falling edge after transfer.
  task automatic sendByte(input logic [7:0] b);
    bit ok;
    ok         = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (byte_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL byte_accept actual=not_accepted required=accepted byte=%02h", b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({byte_ready, load_en, cpu_hold, done, err} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags actual=%b required=00000",
               {byte_ready, load_en, cpu_hold, done, err});
    end
    checks++;
    if (load_data !== 32'h0 || load_addr !== '0) begin
      failures++;
      $display("[TB] FAIL reset_bus actual=%08h/%0h required=0/0", load_data, load_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    int base;
    base = wrAddr.size();
    startSession(6'd1);
    checks++;
    if (cpu_hold !== 1'b1 || byte_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_recv actual=hold%b ready%b required=hold1 ready1", cpu_hold, byte_ready);
    end
    sendByte(8'h13);
    sendByte(8'h00);
    sendByte(8'h50);
    sendByte(8'h00);
    checks++;
    if (load_en !== 1'b1 || load_data !== 32'h00500013 || load_addr !== '0 || byte_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_write actual=en%b %08h @%0h ready%b required=en1 00500013 @0 ready0",
               load_en, load_data, load_addr, byte_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || load_en !== 1'b0 || cpu_hold !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_done actual=done%b en%b hold%b err%b required=done1 en0 hold0 err0",
               done, load_en, cpu_hold, err);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || load_data !== 32'h00500013 || (wrAddr.size() - base) != 1) begin
      failures++;
      $display("[TB] FAIL single_after actual=done%b %08h writes%0d required=done0 00500013 writes1",
               done, load_data, wrAddr.size() - base);
    end
  endtask

  task automatic test_gapped();
    logic [31:0] words [3];
    logic [31:0] w;
    int          base;
    bit          sawDone;
    words[0] = 32'h11223344;
    words[1] = 32'hAABBCCDD;
    words[2] = 32'hDEADBEEF;
    base     = wrAddr.size();
    startSession(6'd3);
    for (int wi = 0; wi < 3; wi++) begin
      w = words[wi];
      for (int bi = 0; bi < 4; bi++) begin
        sendByte(w[bi*8 +: 8]);
        @(negedge clk);
      end
    end
    sawDone = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        sawDone = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!sawDone) begin
      failures++;
      $display("[TB] FAIL gapped_done actual=no_done required=done");
    end
    @(negedge clk);
    checks++;
    if ((wrAddr.size() - base) != 3) begin
      failures++;
      $display("[TB] FAIL gapped_count actual=%0d required=3", wrAddr.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wrAddr[base+i] !== ADDR_W'(i * 4) || wrData[base+i] !== words[i]) begin
          failures++;
          $display("[TB] FAIL gapped_write%0d actual=%08h@%0h required=%08h@%0h",
                   i, wrData[base+i], wrAddr[base+i], words[i], i * 4);
        end
      end
    end
  endtask

  task automatic test_bad_length();
    int base;
    int readyBase;
    int holdBase;
    base      = wrAddr.size();
    readyBase = readyCount;
    holdBase  = holdCount;
    startSession(6'd0);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bad0_finish actual=err%b done%b hold%b ready%b required=err1 done0 hold0 ready0",
               err, done, cpu_hold, byte_ready);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || (readyCount - readyBase) != 0 ||
        (holdCount - holdBase) != 0 || (wrAddr.size() - base) != 0) begin
      failures++;
      $display("[TB] FAIL bad0_quiet actual=err%b done%b ready%0d hold%0d writes%0d required=err1 done0 0 0 0",
               err, done, readyCount - readyBase, holdCount - holdBase, wrAddr.size() - base);
    end
    // One past DEPTH must also be rejected; a legal start would raise cpu_hold.
    startSession(6'd33);
    checks++;
    if (err !== 1'b1 || cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bad33 actual=err%b hold%b ready%b required=err1 hold0 ready0",
               err, cpu_hold, byte_ready);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_full_depth();
    int          base;
    logic [31:0] expWord;
    logic [7:0]  b;
    base = wrAddr.size();
    startSession(6'd32);
    checks++;
    if (err !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_start actual=err%b hold%b required=err0 hold1", err, cpu_hold);
    end
    for (int k = 0; k < 128; k++) begin
      if (k == 50) begin
        start     = 1'b1;
        num_words = 6'd5;
      end
      sendByte(8'(k));
      start = 1'b0;
    end
    checks++;
    if (load_en !== 1'b1 || load_addr !== ADDR_W'(124) || load_data !== 32'h7F7E7D7C) begin
      failures++;
      $display("[TB] FAIL full_last actual=en%b %08h@%0h required=en1 7f7e7d7c@7c",
               load_en, load_data, load_addr);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_done actual=done%b hold%b required=done1 hold0", done, cpu_hold);
    end
    @(negedge clk);
    checks++;
    if ((wrAddr.size() - base) != 32) begin
      failures++;
      $display("[TB] FAIL full_count actual=%0d required=32", wrAddr.size() - base);
    end else begin
      for (int i = 0; i < 32; i++) begin
        b       = 8'(i * 4);
        expWord = {b + 8'd3, b + 8'd2, b + 8'd1, b};
        checks++;
        if (wrAddr[base+i] !== ADDR_W'(i * 4) || wrData[base+i] !== expWord) begin
          failures++;
          $display("[TB] FAIL full_write%0d actual=%08h@%0h required=%08h@%0h",
                   i, wrData[base+i], wrAddr[base+i], expWord, i * 4);
        end
      end
    end
  endtask

  task automatic test_reset_mid_session();
    int base;
    base = wrAddr.size();
    startSession(6'd2);
    sendByte(8'h01);
    sendByte(8'h02);
    sendByte(8'h03);
    sendByte(8'h04);
    sendByte(8'hA1);
    sendByte(8'hA2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, load_en, cpu_hold, done, err} !== 5'b0 ||
        load_data !== 32'h0 || load_addr !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_async actual=%b %08h@%0h required=00000 0@0",
               {byte_ready, load_en, cpu_hold, done, err}, load_data, load_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b0 || byte_ready !== 1'b0 || (wrAddr.size() - base) != 1) begin
      failures++;
      $display("[TB] FAIL midreset_abandon actual=hold%b ready%b writes%0d required=hold0 ready0 writes1",
               cpu_hold, byte_ready, wrAddr.size() - base);
    end
    startSession(6'd1);
    sendByte(8'hEF);
    sendByte(8'hBE);
    sendByte(8'hAD);
    sendByte(8'hDE);
    checks++;
    if (load_en !== 1'b1 || load_data !== 32'hDEADBEEF || load_addr !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_reload actual=en%b %08h@%0h required=en1 deadbeef@0",
               load_en, load_data, load_addr);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_done actual=%b required=1", done);
    end
    @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    readyCount = 0;
    holdCount  = 0;
    start      = 1'b0;
    num_words  = 6'd0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    test_reset();
    test_single_word();
    test_gapped();
    test_bad_length();
    test_full_depth();
    test_reset_mid_session();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
